// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU (and its operand register)
// between two requesters. One operation in flight at a time; the result is
// captured after a fixed latency and returned with a done pulse to the owner.
module alu_share_arbiter #(
  parameter int unsigned n   = 4,
  parameter int unsigned LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [n-1:0] a0,
  input  logic [n-1:0] b0,
  input  logic [n-1:0] mode0,
  input  logic [n-1:0] a1,
  input  logic [n-1:0] b1,
  input  logic [n-1:0] mode1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [n-1:0] result,
  output logic [n-1:0] alu_in1,
  output logic [n-1:0] alu_in2,
  output logic [n-1:0] alu_mode,
  output logic         alu_load,
  input  logic [n-1:0] alu_result,
  output logic         busy
);

  localparam int unsigned cw = $clog2(LAT + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [cw-1:0]   cnt_q, cnt_d;
  logic            prio_q, prio_d;
  logic            owner_q, owner_d;
  logic            win;

  logic            gnt0_d, gnt1_d, done0_d, done1_d, alu_load_d, busy_d;
  logic [n-1:0]    result_d, alu_in1_d, alu_in2_d, alu_mode_d;

  // State, counter, pointer and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      alu_load <= 1'b0;
      busy     <= 1'b0;
      result   <= '0;
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_mode <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      gnt0     <= gnt0_d;
      gnt1     <= gnt1_d;
      done0    <= done0_d;
      done1    <= done1_d;
      alu_load <= alu_load_d;
      busy     <= busy_d;
      result   <= result_d;
      alu_in1  <= alu_in1_d;
      alu_in2  <= alu_in2_d;
      alu_mode <= alu_mode_d;
    end
  end

  // Arbitration, latency countdown and next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    win        = 1'b0;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    alu_load_d = 1'b0;
    result_d   = result;
    alu_in1_d  = alu_in1;
    alu_in2_d  = alu_in2;
    alu_mode_d = alu_mode;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Pointer only matters on contention; a lone requester always wins
          win        = (req0 && req1) ? prio_q : req1;
          owner_d    = win;
          prio_d     = ~win;
          cnt_d      = cw'(LAT);
          alu_load_d = 1'b1;
          state_d    = S_WAIT;
          if (win) begin
            alu_in1_d  = a1;
            alu_in2_d  = b1;
            alu_mode_d = mode1;
            gnt1_d     = 1'b1;
          end else begin
            alu_in1_d  = a0;
            alu_in2_d  = b0;
            alu_mode_d = mode0;
            gnt0_d     = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - cw'(1);
        if (cnt_q == cw'(1)) begin
          result_d = alu_result;
          state_d  = S_IDLE;
          if (owner_q) done1_d = 1'b1;
          else         done0_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WAIT);
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a
// randomized run compared against a transaction-timeline reference model.
module tb_alu_share_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned L = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [N-1:0] a0, b0, mode0, a1, b1, mode1;
  logic         gnt0, gnt1, done0, done1, alu_load, busy;
  logic [N-1:0] result, alu_in1, alu_in2, alu_mode, alu_result;

  int errors = 0;
  int checks = 0;

  alu_share_arbiter #(.n(N), .LAT(L)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .mode0(mode0),
    .a1(a1), .b1(b1), .mode1(mode1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_mode(alu_mode),
    .alu_load(alu_load), .alu_result(alu_result), .busy(busy)
  );

  // Bench ALU: sum of the registered operands
  assign alu_result = N'(alu_in1 + alu_in2);

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req0 = 1'b1; req1 = 1'($urandom_range(0, 1));
    a0 = N'($urandom); b0 = N'($urandom); mode0 = N'($urandom);
    a1 = N'($urandom); b1 = N'($urandom); mode1 = N'($urandom);
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, alu_load, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=000000", {gnt0, gnt1, done0, done1, alu_load, busy});
    end
    checks++;
    if ({result, alu_in1, alu_in2, alu_mode} !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", {result, alu_in1, alu_in2, alu_mode});
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({gnt0, gnt1, done0, done1, alu_load, busy, result, alu_in1, alu_in2, alu_mode} !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=0", i,
                 {gnt0, gnt1, done0, done1, alu_load, busy, result, alu_in1, alu_in2, alu_mode});
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    a0 = 4'd3; b0 = 4'd5; mode0 = 4'd1; req0 = 1'b1;
    tick(); // cycle 1
    checks++;
    if ({gnt0, gnt1, alu_load, busy} !== 4'b1011) begin
      errors++;
      $display("FAIL single_gnt got=%b exp=1011", {gnt0, gnt1, alu_load, busy});
    end
    checks++;
    if ({alu_in1, alu_in2, alu_mode} !== {4'd3, 4'd5, 4'd1}) begin
      errors++;
      $display("FAIL single_operands got=%h exp=351", {alu_in1, alu_in2, alu_mode});
    end
    req0 = 1'b0;
    tick(); // cycle 2
    checks++;
    if ({gnt0, alu_load, done0, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL single_wait got=%b exp=0001", {gnt0, alu_load, done0, busy});
    end
    tick(); // cycle 3
    checks++;
    if ({done0, done1, busy} !== 3'b100 || result !== 4'd8) begin
      errors++;
      $display("FAIL single_done got=%b/%0d exp=100/8", {done0, done1, busy}, result);
    end
    tick(); // cycle 4
    checks++;
    if (done0 !== 1'b0 || result !== 4'd8) begin
      errors++;
      $display("FAIL single_hold got=%b/%0d exp=0/8", done0, result);
    end
  endtask

  task automatic test_prio();
    apply_reset();
    a1 = 4'd1; b1 = 4'd1; mode1 = 4'd0; req1 = 1'b1;
    tick(); // cycle 1
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL prio_solo got=%b exp=01", {gnt0, gnt1});
    end
    a0 = 4'd2; b0 = 4'd2; mode0 = 4'd0; req0 = 1'b1;
    a1 = 4'd6; b1 = 4'd1;
    tick(); tick(); // cycle 3
    checks++;
    if ({done0, done1} !== 2'b01 || result !== 4'd2) begin
      errors++;
      $display("FAIL prio_done1 got=%b/%0d exp=01/2", {done0, done1}, result);
    end
    tick(); // cycle 4
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL prio_contend got=%b exp=10", {gnt0, gnt1});
    end
    req0 = 1'b0;
    for (int i = 5; i <= 6; i++) begin
      tick();
      checks++;
      if ({gnt0, gnt1} !== 2'b00) begin
        errors++;
        $display("FAIL prio_quiet cyc=%0d got=%b exp=00", i, {gnt0, gnt1});
      end
    end
    tick(); // cycle 7
    checks++;
    if ({gnt0, gnt1} !== 2'b01 || alu_in1 !== 4'd6) begin
      errors++;
      $display("FAIL prio_follow got=%b/%0d exp=01/6", {gnt0, gnt1}, alu_in1);
    end
    req1 = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_contention();
    logic [1:0] eg, ed;
    apply_reset();
    a0 = 4'd3; b0 = 4'd5; mode0 = 4'd0;
    a1 = 4'd7; b1 = 4'd2; mode1 = 4'd2;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      eg = {(c == 1 || c == 7), (c == 4 || c == 10)};
      ed = {(c == 3 || c == 9), (c == 6 || c == 12)};
      checks++;
      if ({gnt0, gnt1} !== eg) begin
        errors++;
        $display("FAIL contend_gnt cyc=%0d got=%b exp=%b", c, {gnt0, gnt1}, eg);
      end
      checks++;
      if ({done0, done1} !== ed) begin
        errors++;
        $display("FAIL contend_done cyc=%0d got=%b exp=%b", c, {done0, done1}, ed);
      end
      if (ed != 2'b00) begin
        checks++;
        if (result !== (ed[1] ? 4'd8 : 4'd9)) begin
          errors++;
          $display("FAIL contend_result cyc=%0d got=%0d exp=%0d", c, result, ed[1] ? 8 : 9);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_hold();
    apply_reset();
    a0 = 4'd3; b0 = 4'd5; mode0 = 4'd1; req0 = 1'b1;
    tick(); // cycle 1
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL hold_gnt got=%b exp=1", gnt0);
    end
    a0 = 4'd15; req0 = 1'b0;
    tick(); // cycle 2
    checks++;
    if (alu_in1 !== 4'd3) begin
      errors++;
      $display("FAIL hold_in1 got=%0d exp=3", alu_in1);
    end
    tick(); // cycle 3
    checks++;
    if (done0 !== 1'b1 || result !== 4'd8 || alu_in1 !== 4'd3) begin
      errors++;
      $display("FAIL hold_done got=%b/%0d/%0d exp=1/8/3", done0, result, alu_in1);
    end
  endtask

  task automatic test_reset_wait();
    apply_reset();
    a0 = 4'd4; b0 = 4'd4; mode0 = 4'd0; req0 = 1'b1;
    tick(); // cycle 1
    req0 = 1'b0;
    tick(); // cycle 2
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_busy got=%b exp=1", busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done0, done1, result} !== '0) begin
      errors++;
      $display("FAIL rstwait_abort got=%b exp=0", {busy, done0, done1, result});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({done0, done1, busy, result} !== '0) begin
        errors++;
        $display("FAIL rstwait_nodone cyc=%0d got=%b exp=0", i, {done0, done1, busy, result});
      end
    end
    a0 = 4'd1; b0 = 4'd2; a1 = 4'd3; b1 = 4'd3; req0 = 1'b1; req1 = 1'b1;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL rstwait_regrant got=%b exp=10", {gnt0, gnt1});
    end
    req0 = 1'b0;
    tick(); tick();
    checks++;
    if (done0 !== 1'b1 || result !== 4'd3) begin
      errors++;
      $display("FAIL rstwait_done got=%b/%0d exp=1/3", done0, result);
    end
    tick();
    checks++;
    if (gnt1 !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_gnt1 got=%b exp=1", gnt1);
    end
    req1 = 1'b0;
    repeat (3) tick();
  endtask

  // Random traffic against a timeline model: each accepted operation owns
  // cycles g..g+L, grants land one cycle after acceptance, and the pointer
  // only arbitrates when both requests are present.
  task automatic test_random();
    int           free_cyc;
    int           g;
    bit           have_op;
    bit           m_owner, m_prio, w;
    logic [N-1:0] m_a, m_b, m_mode, m_val, m_result;
    logic [5:0]   exp_ctl;
    logic [3*N-1:0] exp_in;

    apply_reset();
    free_cyc = 0; g = 0; have_op = 1'b0; m_owner = 1'b0; m_prio = 1'b0;
    m_a = '0; m_b = '0; m_mode = '0; m_val = '0; m_result = '0;

    for (int c = 0; c < 600; c++) begin
      if (have_op && c == g + int'(L)) m_result = m_val;
      exp_ctl = {have_op && c == g && !m_owner,
                 have_op && c == g && m_owner,
                 have_op && c == g,
                 have_op && c == g + int'(L) && !m_owner,
                 have_op && c == g + int'(L) && m_owner,
                 have_op && c >= g && c < g + int'(L)};
      exp_in = have_op ? {m_a, m_b, m_mode} : '0;
      checks++;
      if ({gnt0, gnt1, alu_load, done0, done1, busy} !== exp_ctl) begin
        errors++;
        $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", c,
                 {gnt0, gnt1, alu_load, done0, done1, busy}, exp_ctl);
      end
      checks++;
      if (result !== m_result) begin
        errors++;
        $display("FAIL rnd_result cyc=%0d got=%0d exp=%0d", c, result, m_result);
      end
      checks++;
      if ({alu_in1, alu_in2, alu_mode} !== exp_in) begin
        errors++;
        $display("FAIL rnd_alu_in cyc=%0d got=%h exp=%h", c, {alu_in1, alu_in2, alu_mode}, exp_in);
      end

      // Requesters: hold until granted, then drop or issue a new operation
      if (!req0 || gnt0) begin
        req0 = 1'($urandom_range(0, 1));
        a0 = N'($urandom); b0 = N'($urandom); mode0 = N'($urandom);
      end
      if (!req1 || gnt1) begin
        req1 = 1'($urandom_range(0, 1));
        a1 = N'($urandom); b1 = N'($urandom); mode1 = N'($urandom);
      end

      // Acceptance at the edge ending this cycle
      if (c >= free_cyc && (req0 || req1)) begin
        w        = (req0 && req1) ? m_prio : req1;
        m_prio   = ~w;
        m_owner  = w;
        m_a      = w ? a1 : a0;
        m_b      = w ? b1 : b0;
        m_mode   = w ? mode1 : mode0;
        m_val    = N'(m_a + m_b);
        g        = c + 1;
        free_cyc = c + 1 + int'(L);
        have_op  = 1'b1;
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; mode0 = '0;
    a1 = '0; b1 = '0; mode1 = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single();
    test_prio();
    test_contention();
    test_hold();
    test_reset_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
